// File: rtl/seven_segment_decoder.sv
// ---------------------------------------------------------------------------
// SevenSegmentDecoder
//
// Purpose:
//   Watches the segment and digit strobe lines that normally drive a
//   multiplexed, active-low, 8-digit seven-segment display and recovers
//   the hex value, the decimal-point state and a legality flag for each
//   digit. A pattern is captured only after it has held unchanged for
//   SETTLE_CYCLES consecutive clock edges. This rejects glitches and
//   ghosting while the scan moves from one digit to the next.
//
// Ports:
//   clock          in   1   system clock, all state on the rising edge
//   reset          in   1   asynchronous, active-high reset
//   segmentEnableN in   8   active-low segments, bit0..6 = a..g, bit7 = dp
//   digitEnableN   in   8   active-low digit strobes, bit i = digit i
//   clearError     in   1   synchronous clear of the sticky error flag
//   data           out  32  decoded nibbles, nibble i = data[4i+3:4i]
//   pointEnable    out  8   captured decimal-point state per digit, 1 = lit
//   digitValid     out  8   1 = last capture of digit i was a legal glyph
//   frameDone      out  1   one-cycle pulse once all 8 digits are captured
//   error          out  1   sticky flag, several digit strobes active at once
// ---------------------------------------------------------------------------
module seven_segment_decoder #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  segmentEnableN,
    input  logic [7:0]  digitEnableN,
    input  logic        clearError,
    output logic [31:0] data,
    output logic [7:0]  pointEnable,
    output logic [7:0]  digitValid,
    output logic        frameDone,
    output logic        error
);

    localparam logic [15:0] SETTLE = 16'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SETTLING,
        CAPTURED
    } stateT;

    // Number of active (low) strobes in an 8-bit active-low vector.
    function automatic logic [3:0] countLow(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, ~v[i]};
        end
        return n;
    endfunction

    // Position of the active strobe. Only used when exactly one is low.
    function automatic logic [2:0] lowIndex(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!v[i]) begin
                idx = i[2:0];
            end
        end
        return idx;
    endfunction

    // Active-high gfedcba -> {legal, nibble}. Unknown shapes decode to 0.
    function automatic logic [4:0] decodeGlyph(input logic [6:0] g);
        logic [4:0] r;
        case (g)
            7'h3F:   r = 5'h10;
            7'h06:   r = 5'h11;
            7'h5B:   r = 5'h12;
            7'h4F:   r = 5'h13;
            7'h66:   r = 5'h14;
            7'h6D:   r = 5'h15;
            7'h7D:   r = 5'h16;
            7'h07:   r = 5'h17;
            7'h7F:   r = 5'h18;
            7'h6F:   r = 5'h19;
            7'h77:   r = 5'h1A;
            7'h7C:   r = 5'h1B;
            7'h39:   r = 5'h1C;
            7'h5E:   r = 5'h1D;
            7'h79:   r = 5'h1E;
            7'h71:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    stateT       stateQ, stateD;
    logic [15:0] counterQ, counterD;
    logic [7:0]  sampleSegQ, sampleDigQ;
    logic [31:0] dataQ, dataD;
    logic [7:0]  pointQ, pointD;
    logic [7:0]  validQ, validD;
    logic [7:0]  seenQ, seenD;
    logic        frameDoneQ, frameDoneD;
    logic        errorQ, errorD;

    logic        capture;
    logic        restart;
    logic        oneStrobe;
    logic        samePattern;
    logic        multiSampled;
    logic [2:0]  capIndex;
    logic [4:0]  glyph;
    logic [7:0]  seenMerged;

    // The counter tracks how many consecutive edges the sample register
    // will have held the current pin pattern once this edge completes.
    // Comparing the pins with the sample register therefore gives a
    // capture on the SETTLE_CYCLES-th edge of an unchanged pattern.
    assign oneStrobe    = (countLow(digitEnableN) == 4'd1);
    assign samePattern  = ({segmentEnableN, digitEnableN} == {sampleSegQ, sampleDigQ});
    assign multiSampled = (countLow(sampleDigQ) >= 4'd2);
    assign capIndex     = lowIndex(digitEnableN);
    assign glyph        = decodeGlyph(~segmentEnableN[6:0]);

    // Next-state logic for the settle FSM. A new single-strobe pattern
    // always restarts the count at one. If SETTLE_CYCLES is 1, that first
    // edge is already enough to capture.
    always_comb begin
        stateD   = stateQ;
        counterD = counterQ;
        capture  = 1'b0;
        restart  = 1'b0;
        case (stateQ)
            IDLE: begin
                counterD = 16'd0;
                restart  = oneStrobe;
            end
            SETTLING: begin
                if (!oneStrobe) begin
                    stateD   = IDLE;
                    counterD = 16'd0;
                end else if (!samePattern) begin
                    restart = 1'b1;
                end else begin
                    counterD = (counterQ >= SETTLE) ? SETTLE : counterQ + 16'd1;
                    if (counterD == SETTLE) begin
                        capture = 1'b1;
                        stateD  = CAPTURED;
                    end
                end
            end
            CAPTURED: begin
                if (!samePattern) begin
                    if (oneStrobe) begin
                        restart = 1'b1;
                    end else begin
                        stateD   = IDLE;
                        counterD = 16'd0;
                    end
                end
            end
            default: begin
                stateD   = IDLE;
                counterD = 16'd0;
            end
        endcase
        if (restart) begin
            counterD = 16'd1;
            if (SETTLE == 16'd1) begin
                capture = 1'b1;
                stateD  = CAPTURED;
            end else begin
                stateD = SETTLING;
            end
        end
    end

    // Capture datapath. Only the strobed digit changes. The frame pulse
    // fires when a capture completes the seen set, and the set restarts
    // empty on that same edge.
    always_comb begin
        dataD      = dataQ;
        pointD     = pointQ;
        validD     = validQ;
        seenD      = seenQ;
        frameDoneD = 1'b0;
        seenMerged = seenQ | (8'b0000_0001 << capIndex);
        if (capture) begin
            dataD[{capIndex, 2'b00} +: 4] = glyph[3:0];
            validD[capIndex]              = glyph[4];
            pointD[capIndex]              = ~segmentEnableN[7];
            if (seenMerged == 8'hFF) begin
                frameDoneD = 1'b1;
                seenD      = 8'h00;
            end else begin
                seenD = seenMerged;
            end
        end
    end

    // A set request wins over a clear on the same edge.
    always_comb begin
        errorD = errorQ;
        if (multiSampled) begin
            errorD = 1'b1;
        end else if (clearError) begin
            errorD = 1'b0;
        end
    end

    // All state, including the input sample register, on one clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stateQ     <= IDLE;
            counterQ   <= 16'd0;
            sampleSegQ <= 8'hFF;
            sampleDigQ <= 8'hFF;
            dataQ      <= 32'd0;
            pointQ     <= 8'd0;
            validQ     <= 8'd0;
            seenQ      <= 8'd0;
            frameDoneQ <= 1'b0;
            errorQ     <= 1'b0;
        end else begin
            stateQ     <= stateD;
            counterQ   <= counterD;
            sampleSegQ <= segmentEnableN;
            sampleDigQ <= digitEnableN;
            dataQ      <= dataD;
            pointQ     <= pointD;
            validQ     <= validD;
            seenQ      <= seenD;
            frameDoneQ <= frameDoneD;
            errorQ     <= errorD;
        end
    end

    assign data        = dataQ;
    assign pointEnable = pointQ;
    assign digitValid  = validQ;
    assign frameDone   = frameDoneQ;
    assign error       = errorQ;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// ---------------------------------------------------------------------------
// tb_seven_segment_decoder
//
// Purpose:
//   Self-checking bench for seven_segment_decoder with SETTLE_CYCLES = 4.
//   A reference model inside the bench tracks how long each pin pattern
//   has been held. It captures the pattern when that run length first
//   reaches the settle count. On every falling edge, the DUT outputs are
//   compared with this model. Directed scenarios add fixed literal
//   expectations. These are followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_seven_segment_decoder;

    localparam int S = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  segmentEnableN;
    logic [7:0]  digitEnableN;
    logic        clearError;
    logic [31:0] data;
    logic [7:0]  pointEnable;
    logic [7:0]  digitValid;
    logic        frameDone;
    logic        error;

    int compared   = 0;
    int mismatched = 0;
    int frameCount = 0;

    // Reference model state
    logic [15:0] lastIn;
    int          run;
    logic [7:0]  sDig;
    logic [31:0] mData;
    logic [7:0]  mPoint;
    logic [7:0]  mValid;
    logic [7:0]  mSeen;
    logic        mFrame;
    logic        mError;
    int          mIdx;
    logic [3:0]  mNib;
    logic        mOk;

    logic [6:0] glyphTable [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seven_segment_decoder #(.SETTLE_CYCLES(S)) dut (
        .clock          (clock),
        .reset          (reset),
        .segmentEnableN (segmentEnableN),
        .digitEnableN   (digitEnableN),
        .clearError     (clearError),
        .data           (data),
        .pointEnable    (pointEnable),
        .digitValid     (digitValid),
        .frameDone      (frameDone),
        .error          (error)
    );

    always #5 clock = ~clock;

    function automatic int lowCount(input logic [7:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (!v[i]) n++;
        end
        return n;
    endfunction

    task automatic modelReset();
        lastIn = 16'hFFFF;
        run    = 0;
        sDig   = 8'hFF;
        mData  = 32'd0;
        mPoint = 8'd0;
        mValid = 8'd0;
        mSeen  = 8'd0;
        mFrame = 1'b0;
        mError = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: the error flag looks at last edge's strobes.
    // A pattern is captured on the edge where its hold count first reaches S.
    initial begin
        forever begin
            @(posedge clock);
            if (!reset) begin
                if (lowCount(sDig) >= 2) mError = 1'b1;
                else if (clearError) mError = 1'b0;
                sDig = digitEnableN;
                if ({segmentEnableN, digitEnableN} == lastIn) begin
                    if (run <= S) run++;
                end else begin
                    run = 1;
                end
                lastIn = {segmentEnableN, digitEnableN};
                mFrame = 1'b0;
                if (run == S && lowCount(digitEnableN) == 1) begin
                    mIdx = 0;
                    for (int i = 0; i < 8; i++) if (!digitEnableN[i]) mIdx = i;
                    mNib = 4'd0;
                    mOk  = 1'b0;
                    for (int g = 0; g < 16; g++) begin
                        if (glyphTable[g] == ~segmentEnableN[6:0]) begin
                            mNib = 4'(g);
                            mOk  = 1'b1;
                        end
                    end
                    mData[mIdx*4 +: 4] = mNib;
                    mValid[mIdx]       = mOk;
                    mPoint[mIdx]       = ~segmentEnableN[7];
                    mSeen[mIdx]        = 1'b1;
                    if (mSeen == 8'hFF) begin
                        mFrame = 1'b1;
                        mSeen  = 8'h00;
                    end
                end
            end
        end
    end

    // Compare process: every falling edge, DUT against the model.
    initial begin
        forever begin
            @(negedge clock);
            checkOutput("data",        data,                 mData);
            checkOutput("pointEnable", {24'd0, pointEnable}, {24'd0, mPoint});
            checkOutput("digitValid",  {24'd0, digitValid},  {24'd0, mValid});
            checkOutput("frameDone",   {31'd0, frameDone},   {31'd0, mFrame});
            checkOutput("error",       {31'd0, error},       {31'd0, mError});
            if (frameDone) frameCount++;
        end
    end

    task automatic applyStimulus(input logic [7:0] seg, input logic [7:0] dig, input logic clr, input int cycles);
        segmentEnableN = seg;
        digitEnableN   = dig;
        clearError     = clr;
        repeat (cycles) @(negedge clock);
    endtask

    task automatic applyReset(input int cycles);
        @(negedge clock);
        #2;
        reset = 1'b1;
        modelReset();
        repeat (cycles) @(negedge clock);
        #2;
        reset = 1'b0;
    endtask

    task automatic scanDigits(input int count, input logic [7:0] dpMask);
        for (int d = 0; d < count; d++) begin
            applyStimulus(~{dpMask[d], glyphTable[d]}, ~(8'h01 << d), 1'b0, 6);
        end
    endtask

    initial begin
        reset          = 1'b1;
        segmentEnableN = 8'hFF;
        digitEnableN   = 8'hFF;
        clearError     = 1'b0;
        modelReset();
        repeat (3) @(negedge clock);
        #2;
        reset = 1'b0;
        applyStimulus(8'hFF, 8'hFF, 1'b0, 2);
        #1;
        checkOutput("resetData",  data, 32'd0);
        checkOutput("resetError", {31'd0, error}, 32'd0);

        // Glyph 2 held only 3 edges: no capture. Held 4 edges: capture.
        applyStimulus(8'hA4, 8'hFE, 1'b0, 3);
        applyStimulus(8'hFF, 8'hFF, 1'b0, 2);
        #1;
        checkOutput("short3Data",  {28'd0, data[3:0]}, 32'd0);
        checkOutput("short3Valid", {31'd0, digitValid[0]}, 32'd0);
        applyStimulus(8'hA4, 8'hFE, 1'b0, 4);
        #1;
        checkOutput("hold4Data",  {28'd0, data[3:0]}, 32'd2);
        checkOutput("hold4Valid", {31'd0, digitValid[0]}, 32'd1);
        checkOutput("hold4Point", {31'd0, pointEnable[0]}, 32'd0);

        // Full scan, digit 3 dp lit
        frameCount = 0;
        scanDigits(8, 8'h08);
        applyStimulus(8'hFF, 8'hFF, 1'b0, 3);
        #1;
        checkOutput("scanData",   data, 32'h76543210);
        checkOutput("scanPoint",  {24'd0, pointEnable}, 32'h08);
        checkOutput("scanValid",  {24'd0, digitValid}, 32'hFF);
        checkOutput("scanFrames", frameCount, 32'd1);

        // Two strobes: sticky error, no captures, then clear
        applyStimulus(~{1'b0, glyphTable[1]}, 8'hFC, 1'b0, 10);
        #1;
        checkOutput("multiError", {31'd0, error}, 32'd1);
        checkOutput("multiData",  data, 32'h76543210);
        applyStimulus(8'hFF, 8'hFF, 1'b0, 2);
        #1;
        checkOutput("stickyError", {31'd0, error}, 32'd1);
        applyStimulus(8'hFF, 8'hFF, 1'b1, 1);
        applyStimulus(8'hFF, 8'hFF, 1'b0, 1);
        #1;
        checkOutput("clearedError", {31'd0, error}, 32'd0);
        applyStimulus(8'hFF, 8'hF0, 1'b1, 4);
        #1;
        checkOutput("setWinsError", {31'd0, error}, 32'd1);
        applyStimulus(8'hFF, 8'hFF, 1'b1, 2);
        #1;
        checkOutput("clear2Error", {31'd0, error}, 32'd0);

        // Digit 5: all segments plus dp lit, then blank
        applyStimulus(8'h00, 8'hDF, 1'b0, 6);
        applyStimulus(8'hFF, 8'hDF, 1'b0, 6);
        #1;
        checkOutput("blankNibble", {28'd0, data[23:20]}, 32'd0);
        checkOutput("blankValid",  {31'd0, digitValid[5]}, 32'd0);
        checkOutput("blankPoint",  {31'd0, pointEnable[5]}, 32'd0);

        // Toggling on digit 1 never settles
        for (int t = 0; t < 10; t++) begin
            applyStimulus(~{1'b0, glyphTable[(t % 2 == 0) ? 9 : 10]}, 8'hFD, 1'b0, 2);
        end
        #1;
        checkOutput("toggleNibble", {28'd0, data[7:4]}, 32'd1);
        applyStimulus(~{1'b0, glyphTable[12]}, 8'hFD, 1'b0, 4);
        #1;
        checkOutput("settledNibble", {28'd0, data[7:4]}, 32'hC);

        // Randomized phase
        for (int n = 0; n < 250; n++) begin
            int r;
            logic [7:0] dig;
            logic [7:0] seg;
            r = $urandom_range(0, 9);
            if (r < 7)       dig = ~(8'h01 << $urandom_range(0, 7));
            else if (r == 7) dig = 8'hFF;
            else             dig = 8'($urandom);
            if ($urandom_range(0, 4) == 0) seg = 8'($urandom);
            else seg = ~{1'($urandom_range(0, 1)), glyphTable[$urandom_range(0, 15)]};
            applyStimulus(seg, dig, ($urandom_range(0, 7) == 0), $urandom_range(1, 7));
        end

        // Reset part-way through a frame discards progress
        applyReset(2);
        scanDigits(5, 8'h00);
        applyStimulus(~{1'b0, glyphTable[5]}, 8'hDF, 1'b0, 2);
        applyReset(2);
        #1;
        checkOutput("rstData",  data, 32'd0);
        checkOutput("rstValid", {24'd0, digitValid}, 32'd0);
        checkOutput("rstPoint", {24'd0, pointEnable}, 32'd0);
        frameCount = 0;
        scanDigits(8, 8'h00);
        applyStimulus(8'hFF, 8'hFF, 1'b0, 3);
        #1;
        checkOutput("rescanFrames", frameCount, 32'd1);
        checkOutput("rescanData",   data, 32'h76543210);
        checkOutput("rescanValid",  {24'd0, digitValid}, 32'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
